// File: rtl/tour_length_eval.sv
// tour_length_eval
//   Computes the closed-tour Euclidean length of one chromosome (route) over
//   NUM_CITIES cities, including the return edge from the last city to the
//   first. Each edge length is floor(sqrt(dx^2+dy^2)) from a restoring
//   bit-serial square root taking SIZE+1 cycles. Also tracks the shortest
//   valid tour seen since the last clear, together with its chromosome ID.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        start request, sampled only in IDLE
//   chrom_id     chromosome ID, latched on accepted start
//   route        city index per slot, slot k at [k*IDX_W +: IDX_W]
//   coord_x/y    coordinates per city, slot k at [k*SIZE +: SIZE]
//   clear_best   synchronous clear of the best tracker
//   busy         high in every state except IDLE
//   done         one-cycle result-valid pulse
//   route_err    with done: route contained an index >= NUM_CITIES
//   tour_len     tour length (all ones on route_err), held until next done
//   best_valid   best_len/best_id hold a result
//   best_len     shortest valid tour since last clear
//   best_id      chrom_id belonging to best_len
module tour_length_eval #(
  parameter int SIZE       = 8,
  parameter int NUM_CITIES = 5,
  parameter int IDX_W      = 3,
  parameter int ID_W       = 4,
  parameter int DIST_W     = SIZE + 1,
  parameter int LEN_W      = DIST_W + IDX_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ID_W-1:0]             chrom_id,
  input  logic [NUM_CITIES*IDX_W-1:0] route,
  input  logic [NUM_CITIES*SIZE-1:0]  coord_x,
  input  logic [NUM_CITIES*SIZE-1:0]  coord_y,
  input  logic                        clear_best,
  output logic                        busy,
  output logic                        done,
  output logic                        route_err,
  output logic [LEN_W-1:0]            tour_len,
  output logic                        best_valid,
  output logic [LEN_W-1:0]            best_len,
  output logic [ID_W-1:0]             best_id
);

  localparam int RAD_W = 2 * DIST_W;   // radicand padded to an even bit count
  localparam int REM_W = DIST_W + 2;
  localparam int CNT_W = $clog2(SIZE + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SIZE);
  localparam logic [IDX_W-1:0] EDGE_LAST = IDX_W'(NUM_CITIES - 1);
  localparam logic [IDX_W:0]   NC        = (IDX_W + 1)'(NUM_CITIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SQRT,
    S_ACC,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [NUM_CITIES*IDX_W-1:0] route_q, route_d;
  logic [NUM_CITIES*SIZE-1:0]  x_q, x_d;
  logic [NUM_CITIES*SIZE-1:0]  y_q, y_d;
  logic [ID_W-1:0]             id_q, id_d;
  logic                        err_q, err_d;
  logic [IDX_W-1:0]            edge_q, edge_d;
  logic [LEN_W-1:0]            acc_q, acc_d;
  logic [RAD_W-1:0]            rad_q, rad_d;
  logic [REM_W-1:0]            rem_q, rem_d;
  logic [DIST_W-1:0]           root_q, root_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [LEN_W-1:0]            tour_len_q, tour_len_d;
  logic                        route_err_q, route_err_d;
  logic                        best_valid_q, best_valid_d;
  logic [LEN_W-1:0]            best_len_q, best_len_d;
  logic [ID_W-1:0]             best_id_q, best_id_d;

  // Route validity is checked on the incoming route so a bad route can go
  // straight to DONE without spending any edge cycles.
  logic route_bad;
  always_comb begin
    route_bad = 1'b0;
    for (int unsigned k = 0; k < NUM_CITIES; k++) begin
      if ({1'b0, route[k*IDX_W +: IDX_W]} >= NC) route_bad = 1'b1;
    end
  end

  // Edge endpoint selection and squared distance.
  logic [IDX_W-1:0]   edge_nx, idx_a, idx_b;
  logic [SIZE-1:0]    xa, xb, ya, yb, dx, dy;
  logic [2*SIZE-1:0]  dx2, dy2;
  logic [2*SIZE:0]    rad_c;

  always_comb begin
    edge_nx = (edge_q == EDGE_LAST) ? '0 : edge_q + 1'b1;
    idx_a   = route_q[edge_q*IDX_W +: IDX_W];
    idx_b   = route_q[edge_nx*IDX_W +: IDX_W];
    xa      = x_q[idx_a*SIZE +: SIZE];
    xb      = x_q[idx_b*SIZE +: SIZE];
    ya      = y_q[idx_a*SIZE +: SIZE];
    yb      = y_q[idx_b*SIZE +: SIZE];
    dx      = (xa >= xb) ? xa - xb : xb - xa;
    dy      = (ya >= yb) ? ya - yb : yb - ya;
    dx2     = {{SIZE{1'b0}}, dx} * {{SIZE{1'b0}}, dx};
    dy2     = {{SIZE{1'b0}}, dy} * {{SIZE{1'b0}}, dy};
    rad_c   = {1'b0, dx2} + {1'b0, dy2};
  end

  // One restoring square-root step: bring down the next two radicand bits and
  // try to subtract 4*root+1; the result bit is whether that succeeded.
  logic [REM_W-1:0] rem_sh, trial;
  logic             sq_ge;
  always_comb begin
    rem_sh = REM_W'({rem_q, rad_q[RAD_W-1 -: 2]});
    trial  = {root_q, 2'b01};
    sq_ge  = (rem_sh >= trial);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = route_bad ? S_DONE : S_LOAD;
      S_LOAD: state_d = S_SQRT;
      S_SQRT: if (cnt_q == CNT_LAST) state_d = S_ACC;
      S_ACC:  state_d = (edge_q == EDGE_LAST) ? S_DONE : S_LOAD;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Datapath next-state
  always_comb begin
    route_d      = route_q;
    x_d          = x_q;
    y_d          = y_q;
    id_d         = id_q;
    err_d        = err_q;
    edge_d       = edge_q;
    acc_d        = acc_q;
    rad_d        = rad_q;
    rem_d        = rem_q;
    root_d       = root_q;
    cnt_d        = cnt_q;
    tour_len_d   = tour_len_q;
    route_err_d  = route_err_q;
    best_valid_d = best_valid_q;
    best_len_d   = best_len_q;
    best_id_d    = best_id_q;

    if (clear_best) begin
      best_valid_d = 1'b0;
      best_len_d   = '0;
      best_id_d    = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          route_d = route;
          x_d     = coord_x;
          y_d     = coord_y;
          id_d    = chrom_id;
          edge_d  = '0;
          acc_d   = '0;
          err_d   = route_bad;
          // Result registers are loaded on entry to DONE so tour_len and
          // route_err are already valid while done is high.
          if (route_bad) begin
            tour_len_d  = '1;
            route_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        rad_d  = {1'b0, rad_c};
        rem_d  = '0;
        root_d = '0;
        cnt_d  = '0;
      end
      S_SQRT: begin
        rad_d  = rad_q << 2;
        rem_d  = sq_ge ? rem_sh - trial : rem_sh;
        root_d = {root_q[DIST_W-2:0], sq_ge};
        cnt_d  = cnt_q + 1'b1;
      end
      S_ACC: begin
        acc_d = acc_q + LEN_W'(root_q);
        if (edge_q == EDGE_LAST) begin
          tour_len_d  = acc_q + LEN_W'(root_q);
          route_err_d = 1'b0;
        end else begin
          edge_d = edge_q + 1'b1;
        end
      end
      S_DONE: begin
        // A clear in the same cycle still admits this result as the new best.
        if (!err_q && (clear_best || !best_valid_q || acc_q < best_len_q)) begin
          best_valid_d = 1'b1;
          best_len_d   = acc_q;
          best_id_d    = id_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      route_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      id_q         <= '0;
      err_q        <= 1'b0;
      edge_q       <= '0;
      acc_q        <= '0;
      rad_q        <= '0;
      rem_q        <= '0;
      root_q       <= '0;
      cnt_q        <= '0;
      tour_len_q   <= '0;
      route_err_q  <= 1'b0;
      best_valid_q <= 1'b0;
      best_len_q   <= '0;
      best_id_q    <= '0;
    end else begin
      route_q      <= route_d;
      x_q          <= x_d;
      y_q          <= y_d;
      id_q         <= id_d;
      err_q        <= err_d;
      edge_q       <= edge_d;
      acc_q        <= acc_d;
      rad_q        <= rad_d;
      rem_q        <= rem_d;
      root_q       <= root_d;
      cnt_q        <= cnt_d;
      tour_len_q   <= tour_len_d;
      route_err_q  <= route_err_d;
      best_valid_q <= best_valid_d;
      best_len_q   <= best_len_d;
      best_id_q    <= best_id_d;
    end
  end

  assign route_err  = route_err_q;
  assign tour_len   = tour_len_q;
  assign best_valid = best_valid_q;
  assign best_len   = best_len_q;
  assign best_id    = best_id_q;

endmodule

// File: tb/tb_tour_length_eval.sv
// tb_tour_length_eval
//   Directed bench for tour_length_eval: reset behaviour, known tours with
//   hand-computed lengths, flooring, best-tour tracking and clear, invalid
//   routes and start handshake while busy.
module tb_tour_length_eval;

  localparam int SIZE       = 8;
  localparam int NUM_CITIES = 5;
  localparam int IDX_W      = 3;
  localparam int ID_W       = 4;
  localparam int DIST_W     = SIZE + 1;
  localparam int LEN_W      = DIST_W + IDX_W;
  localparam int LAT        = 1 + NUM_CITIES * (SIZE + 3);

  typedef int arr5_t [5];

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        start;
  logic [ID_W-1:0]             chrom_id;
  logic [NUM_CITIES*IDX_W-1:0] route;
  logic [NUM_CITIES*SIZE-1:0]  coord_x;
  logic [NUM_CITIES*SIZE-1:0]  coord_y;
  logic                        clear_best;
  logic                        busy;
  logic                        done;
  logic                        route_err;
  logic [LEN_W-1:0]            tour_len;
  logic                        best_valid;
  logic [LEN_W-1:0]            best_len;
  logic [ID_W-1:0]             best_id;

  int n_tests = 0;
  int n_fail  = 0;

  tour_length_eval #(
    .SIZE(SIZE), .NUM_CITIES(NUM_CITIES), .IDX_W(IDX_W), .ID_W(ID_W),
    .DIST_W(DIST_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chrom_id(chrom_id),
    .route(route), .coord_x(coord_x), .coord_y(coord_y),
    .clear_best(clear_best), .busy(busy), .done(done),
    .route_err(route_err), .tour_len(tour_len), .best_valid(best_valid),
    .best_len(best_len), .best_id(best_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_case(input int id, input arr5_t r, input arr5_t xs, input arr5_t ys);
    chrom_id = ID_W'(id);
    for (int k = 0; k < NUM_CITIES; k++) begin
      route[k*IDX_W +: IDX_W] = IDX_W'(r[k]);
      coord_x[k*SIZE +: SIZE] = SIZE'(xs[k]);
      coord_y[k*SIZE +: SIZE] = SIZE'(ys[k]);
    end
  endtask

  task automatic scramble();
    chrom_id = ID_W'($urandom);
    route    = (NUM_CITIES*IDX_W)'($urandom);
    coord_x  = (NUM_CITIES*SIZE)'({$urandom, $urandom});
    coord_y  = (NUM_CITIES*SIZE)'({$urandom, $urandom});
  endtask

  // Called at a negedge in IDLE with operands already driven. Returns at the
  // negedge of the IDLE cycle following done.
  task automatic run(input string tag, input int exp_len, input int exp_err,
                     input int exp_lat, input bit spam, input bit clr_at_done);
    int  n;
    bit  busy_ok;
    start   = 1'b1;
    busy_ok = 1'b1;
    @(posedge clk);
    #1;
    if (spam) scramble();
    else      start = 1'b0;
    for (n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (spam) scramble();
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_tour_len"}, tour_len, exp_len);
    chk({tag, "_route_err"}, route_err, exp_err);
    if (spam) chk({tag, "_busy_held"}, busy_ok, 1);
    if (clr_at_done) clear_best = 1'b1;
    @(negedge clk);
    clear_best = 1'b0;
    if (spam) chk({tag, "_start_in_done_ignored"}, busy, 0);
    else      start = 1'b0;
  endtask

  task automatic chk_best(input string tag, input int v, input int len, input int id);
    chk({tag, "_best_valid"}, best_valid, v);
    chk({tag, "_best_len"}, best_len, len);
    chk({tag, "_best_id"}, best_id, id);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_route_err"}, route_err, 0);
    chk({tag, "_tour_len"}, tour_len, 0);
    chk_best(tag, 0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    rst_n      = 1'b0;
    start      = 1'b0;
    clear_best = 1'b0;
    chrom_id   = '0;
    route      = '0;
    coord_x    = '0;
    coord_y    = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Known tour: edges 5,5,8,10,8.
    set_case(2, '{0,1,2,3,4}, '{0,3,6,6,0}, '{0,4,8,0,8});
    run("tourA_id2", 36, 0, LAT, 1'b0, 1'b0);
    chk_best("tourA_id2", 1, 36, 2);

    // Square 10x10 with a duplicate origin: 10+10+10+10+0.
    set_case(5, '{0,1,2,3,4}, '{0,10,10,0,0}, '{0,0,10,10,0});
    run("tourB_id5", 40, 0, LAT, 1'b0, 1'b0);
    chk_best("tourB_id5", 1, 36, 2);

    // Tie keeps the earlier entry.
    set_case(7, '{0,1,2,3,4}, '{0,3,6,6,0}, '{0,4,8,0,8});
    run("tourA_id7", 36, 0, LAT, 1'b0, 1'b0);
    chk_best("tie", 1, 36, 2);

    clear_best = 1'b1;
    @(negedge clk);
    clear_best = 1'b0;
    chk_best("clear", 0, 0, 0);

    set_case(5, '{0,1,2,3,4}, '{0,10,10,0,0}, '{0,0,10,10,0});
    run("tourB_after_clear", 40, 0, LAT, 1'b0, 1'b0);
    chk_best("tourB_after_clear", 1, 40, 5);

    // 10+15+10+15+0, clear_best raised in the done cycle.
    set_case(9, '{0,1,2,3,4}, '{0,10,10,0,0}, '{0,0,15,15,0});
    run("tourC_clr_done", 50, 0, LAT, 1'b0, 1'b1);
    chk_best("clr_with_done", 1, 50, 9);

    // Invalid index in slot 2.
    set_case(3, '{0,1,6,3,4}, '{0,3,6,6,0}, '{0,4,8,0,8});
    run("bad_route", 4095, 1, 1, 1'b0, 1'b0);
    chk_best("bad_route", 1, 50, 9);

    // Extremes: edges 360,0,0,0,360.
    set_case(1, '{0,1,2,3,4}, '{0,255,255,255,255}, '{0,255,255,255,255});
    run("extremes", 720, 0, LAT, 1'b0, 1'b0);
    chk_best("extremes", 1, 50, 9);

    // start held every cycle with changing operands; only the first counts.
    set_case(11, '{0,1,2,3,4}, '{0,3,6,6,0}, '{0,4,8,0,8});
    run("handshake", 36, 0, LAT, 1'b1, 1'b0);
    chk_best("handshake", 1, 36, 11);

    // Accepted in the IDLE cycle right after done. Flooring: sqrt(2)=1.
    set_case(12, '{0,1,1,1,1}, '{0,1,9,9,9}, '{0,1,9,9,9});
    run("floor", 2, 0, LAT, 1'b0, 1'b0);
    chk_best("floor", 1, 2, 12);

    // Asynchronous reset in the middle of a square-root phase.
    set_case(4, '{0,1,2,3,4}, '{0,3,6,6,0}, '{0,4,8,0,8});
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_busy_before_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrun_no_done", ndone, 0);
    chk_best("midrun_after", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tour_length_eval.md
Name: tour_length_eval

Overview:
Sequential, parametrised successor to the combinational distance and find-max helpers. It computes the closed-tour length of one chromosome (route) over NUM_CITIES city coordinates, including the return edge from the last city to the first. It uses a multi-cycle bit-serial integer square root per edge and keeps a running best (shortest tour) with its chromosome ID across a population. It sits between the population memory and the selection/elitism logic of the GA.

Parameters:
SIZE, 8, coordinate width in bits
NUM_CITIES, 5, cities per route (>=2)
IDX_W, 3, city index width, clog2(NUM_CITIES)
ID_W, 4, chromosome ID width (covers Population_Size 15)
DIST_W, SIZE+1, per-edge distance width
LEN_W, DIST_W+IDX_W, tour length width

Ports:
clk  in  1  clock
rst_n  in  1  reset
start  in  1  start request; sampled only in IDLE
chrom_id  in  ID_W  ID of chromosome; latched on accepted start
route  in  NUM_CITIES*IDX_W  city indices; slot k at bits [k*IDX_W +: IDX_W]; latched on start
coord_x  in  NUM_CITIES*SIZE  X per city, same slot packing; latched on start
coord_y  in  NUM_CITIES*SIZE  Y per city; latched on start
clear_best  in  1  synchronous clear of best tracker
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse with result valid
route_err  out  1  valid with done; route had an index >= NUM_CITIES
tour_len  out  LEN_W  result; held until next done
best_valid  out  1  best_len/best_id hold a result
best_len  out  LEN_W  shortest valid tour since last clear
best_id  out  ID_W  chrom_id of best_len

Behaviour:
- Reset: clk and rst_n form a single clock with asynchronous, active-low reset. While reset is asserted, state goes to IDLE and every output and internal register is 0.
- Reset mid-run aborts the computation with no done pulse. The best tracker is cleared.
- FSM states: IDLE, LOAD, SQRT, ACC, DONE.
- IDLE: on start, latch route, coordinates and chrom_id, set edge=0, acc=0.
  - If any route slot index >= NUM_CITIES, go to DONE with err flagged.
  - Otherwise go to LOAD.
- LOAD (1 cycle): a = route[edge], b = route[(edge+1) mod NUM_CITIES].
  - dx=|x_a-x_b| and dy=|y_a-y_b|, each SIZE bits unsigned.
  - rad=dx²+dy², held in 2*SIZE+1 bits so there is no overflow.
- SQRT (exactly SIZE+1 cycles): restoring bit-serial floor square root of rad.
  - Result is floor(sqrt(rad)) in DIST_W bits. For example, rad 0->0, 1->1, 3->1, 4->2.
  - The cycle count does not depend on the data.
- ACC (1 cycle): acc += dist.
  - If edge==NUM_CITIES-1, go to DONE; otherwise edge++ and go to LOAD.
- DONE (1 cycle): done=1 and tour_len=acc, route_err=0; next state is IDLE.
  - If err: tour_len = all ones, route_err=1, best tracker untouched.
- Latency: with start sampled at edge T, done is high in cycle T+1+NUM_CITIES*(SIZE+3). That is cycle 56 at the defaults. For an invalid route, done is high in cycle T+1.
- Back-to-back: a start in the DONE cycle is ignored. The earliest accepted start is in the IDLE cycle after done.
- start while busy is ignored, and the latched operands are unaffected.
- Best update occurs in DONE when the result is valid and (!best_valid or acc < best_len).
  - On update: best_len=acc, best_id=id, best_valid=1.
  - Ties keep the earlier entry.
- clear_best sets best_valid=0, best_len=0, best_id=0 on the next edge.
  - If clear_best coincides with a valid DONE, the new result is loaded as best (best_valid=1).
- Arithmetic is all unsigned. acc cannot overflow: NUM_CITIES*max_dist fits in LEN_W.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Assert rst_n=0 during SQRT -> IDLE, no done pulse, best cleared.
2. Known tour: cities (0,0),(3,4),(6,8),(6,0),(0,8), route 0,1,2,3,4, id=2.
   - Edge distances are 5,5,8,10,8.
   - done in cycle 56 after start, tour_len=36, route_err=0, best_len=36, best_id=2.
3. Extremes and flooring: c0=(0,0), c1..c4=(255,255), route 0..4 -> tour_len=720 (edges 360,0,0,0,360).
   - Standalone c0=(0,0), c1=(1,1), route 0,1,1,1,1 -> 1+0+0+0+1 = 2.
4. Best tracking sequence:
   - 36/id2, then 40/id5 -> best 36/2.
   - 36/id7 -> best stays 36/2 (tie).
   - clear_best, then 40/id5 -> best 40/5.
   - clear_best in the same cycle as done of 50/id9 -> best 50/9, best_valid=1.
5. Invalid route slot 2 = 6 -> done in cycle T+1, route_err=1, tour_len=4095, best unchanged.
6. Handshake: start pulsed every cycle with changing route and coordinates during a run -> only the first start is accepted, result unchanged, busy high until done. A start in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.
